// File: rtl/uart_program_loader.sv
// UART boot loader: receives an instruction image and a data image as 8N1 bytes,
// assembles big-endian words and emits one-cycle write strobes into IMEM/DMEM.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_DEPTH   = 200,
  parameter int DMEM_DEPTH   = 200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXD,
  output logic        IMEM_WE,
  output logic        DMEM_WE,
  output logic [31:0] WADDR,
  output logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int            CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL       = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF       = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   C_IMEM_DEPTH = 32'(IMEM_DEPTH);
  localparam logic [31:0]   C_DMEM_DEPTH = 32'(DMEM_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    LD_INST_LEN, LD_INST, LD_DATA_LEN, LD_DATA, LD_DONE, LD_DONE_ERR
  } ld_state_t;

  logic          r_rxd_meta;
  logic          r_rxd_sync;
  logic          r_rxd_prev;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_byte_stb;
  logic          r_frame_err;

  ld_state_t     r_ld_state;
  logic [1:0]    r_byte_idx;
  logic [23:0]   r_word_buf;
  logic [31:0]   r_len;
  logic [31:0]   r_wcnt;
  logic          r_imem_we;
  logic          r_dmem_we;
  logic [31:0]   r_waddr;
  logic [31:0]   r_wdata;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [31:0]   w_word;
  logic          w_loading;
  logic          w_rx_active;

  assign w_word      = {r_word_buf, r_shift};
  assign w_loading   = (r_ld_state != LD_DONE) && (r_ld_state != LD_DONE_ERR);
  assign w_rx_active = (r_rx_state == RX_DATA);

  // RXD is asynchronous; idle-high reset values avoid a false start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= RXD;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_state  <= RX_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte_stb  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_stb  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rxd_prev && !r_rxd_sync) begin
            r_rx_state <= RX_START;
            r_clk_cnt  <= '0;
          end
        end
        RX_START: begin
          // Mid-start-bit recheck rejects short glitches.
          if (r_clk_cnt == C_HALF) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == C_FULL) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rxd_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == C_FULL) begin
            r_clk_cnt   <= '0;
            r_byte_stb  <= r_rxd_sync;
            r_frame_err <= !r_rxd_sync;
            r_rx_state  <= RX_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ld_state <= LD_INST_LEN;
      r_byte_idx <= '0;
      r_word_buf <= '0;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_imem_we  <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      if (w_loading && w_rx_active) r_busy <= 1'b1;

      if (w_loading && r_frame_err) begin
        r_err      <= 1'b1;
        r_busy     <= 1'b0;
        r_ld_state <= LD_DONE_ERR;
      end else if (w_loading && r_byte_stb) begin
        r_word_buf <= {r_word_buf[15:0], r_shift};
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          case (r_ld_state)
            LD_INST_LEN: begin
              r_len  <= w_word;
              r_wcnt <= '0;
              if (w_word > C_IMEM_DEPTH) begin
                r_err      <= 1'b1;
                r_busy     <= 1'b0;
                r_ld_state <= LD_DONE_ERR;
              end else if (w_word == 32'd0) begin
                r_ld_state <= LD_DATA_LEN;
              end else begin
                r_ld_state <= LD_INST;
              end
            end
            LD_INST: begin
              r_imem_we <= 1'b1;
              r_waddr   <= r_wcnt;
              r_wdata   <= w_word;
              r_wcnt    <= r_wcnt + 32'd1;
              if (r_wcnt == r_len - 32'd1) r_ld_state <= LD_DATA_LEN;
            end
            LD_DATA_LEN: begin
              r_len  <= w_word;
              r_wcnt <= '0;
              if (w_word > C_DMEM_DEPTH) begin
                r_err      <= 1'b1;
                r_busy     <= 1'b0;
                r_ld_state <= LD_DONE_ERR;
              end else if (w_word == 32'd0) begin
                r_ld_state <= LD_DONE;
              end else begin
                r_ld_state <= LD_DATA;
              end
            end
            LD_DATA: begin
              r_dmem_we <= 1'b1;
              r_waddr   <= r_wcnt;
              r_wdata   <= w_word;
              r_wcnt    <= r_wcnt + 32'd1;
              if (r_wcnt == r_len - 32'd1) r_ld_state <= LD_DONE;
            end
            default: r_ld_state <= r_ld_state;
          endcase
        end
      end

      // DONE trails the state change by a cycle so it follows the last strobe.
      if (r_ld_state == LD_DONE) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign IMEM_WE = r_imem_we;
  assign DMEM_WE = r_dmem_we;
  assign WADDR   = r_waddr;
  assign WDATA   = r_wdata;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed scenarios plus randomized
// images, checked against an image-level model of the expected memory writes.
module tb_uart_program_loader;

  localparam int CPB    = 4;
  localparam int IMEM_D = 200;
  localparam int DMEM_D = 200;

  typedef struct packed {
    logic        imem;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RXD;
  logic        IMEM_WE;
  logic        DMEM_WE;
  logic [31:0] WADDR;
  logic [31:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_we_cyc;
  int done_rise_cyc;
  int both_high;
  logic done_prev;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [7:0]  bytes_q[$];
  bit          exp_done;
  bit          exp_err;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .IMEM_DEPTH  (IMEM_D),
    .DMEM_DEPTH  (DMEM_D)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .RXD    (RXD),
    .IMEM_WE(IMEM_WE),
    .DMEM_WE(DMEM_WE),
    .WADDR  (WADDR),
    .WDATA  (WDATA),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  // Observe outputs on the falling edge, well away from the active edge.
  always @(negedge CLK) begin
    wr_t w;
    cyc++;
    if (IMEM_WE || DMEM_WE) begin
      w = {IMEM_WE, WADDR, WDATA};
      got_q.push_back(w);
      last_we_cyc = cyc;
    end
    if (IMEM_WE && DMEM_WE) both_high++;
    if (DONE && !done_prev) done_rise_cyc = cyc;
    done_prev = DONE;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RXD = 1'b1;
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    got_q.delete();
    last_we_cyc   = -1;
    done_rise_cyc = -1;
    both_high     = 0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(CPB);
    end
    RXD = stop_ok;
    tick(CPB);
    RXD = 1'b1;
    tick(2);
  endtask

  task automatic send_all(input int bad);
    for (int i = 0; i < bytes_q.size(); i++) send_byte(bytes_q[i], i != bad);
    tick(10);
  endtask

  // Image-level reference: split the bytes preceding any bad frame into words,
  // then walk length/payload sections and list the writes they imply.
  task automatic run_model(input int bad);
    logic [31:0] words[$];
    logic [31:0] len;
    int          nb;
    int          idx;
    bit          ok;
    wr_t         w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    nb  = (bad >= 0) ? bad : bytes_q.size();
    for (int i = 0; i + 3 < nb; i += 4)
      words.push_back({bytes_q[i], bytes_q[i+1], bytes_q[i+2], bytes_q[i+3]});
    idx = 0;
    ok  = 1'b1;
    for (int sec = 0; sec < 2 && ok; sec++) begin
      if (idx >= words.size()) begin
        ok = 1'b0;
        break;
      end
      len = words[idx];
      idx++;
      if (len > 32'((sec == 0) ? IMEM_D : DMEM_D)) begin
        exp_err = 1'b1;
        ok      = 1'b0;
        break;
      end
      for (int k = 0; k < int'(len); k++) begin
        if (idx >= words.size()) begin
          ok = 1'b0;
          break;
        end
        w = {sec == 0, 32'(k), words[idx]};
        exp_q.push_back(w);
        idx++;
      end
    end
    if (ok) exp_done = 1'b1;
    else if (bad >= 0) exp_err = 1'b1;
  endtask

  task automatic load_main_image();
    bytes_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h00, 8'h00, 8'h2A};
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({IMEM_WE, DMEM_WE, WADDR, WDATA, BUSY, DONE, ERR} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got we=%b%b addr=%h data=%h busy=%b done=%b err=%b want all 0",
               IMEM_WE, DMEM_WE, WADDR, WDATA, BUSY, DONE, ERR);
    end
    $display("test_reset: outputs after reset checked");
  endtask

  task automatic test_main();
    wr_t want[3];
    want[0] = {1'b1, 32'd0, 32'h20010005};
    want[1] = {1'b1, 32'd1, 32'h08000000};
    want[2] = {1'b0, 32'd0, 32'h0000002A};
    do_reset();
    load_main_image();
    send_byte(bytes_q[0], 1'b1);
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL main_busy got %b want 1", BUSY);
    end
    for (int i = 1; i < bytes_q.size(); i++) send_byte(bytes_q[i], 1'b1);
    tick(10);
    n_checks++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL main_count got %0d writes want 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== want[i]) begin
        n_fail++;
        $display("FAIL main_wr%0d got %h want %h", i, got_q[i], want[i]);
      end
    end
    n_checks++;
    if (DONE !== 1'b1 || ERR !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL main_status got done=%b err=%b busy=%b want 1 0 0", DONE, ERR, BUSY);
    end
    n_checks++;
    if (done_rise_cyc != last_we_cyc + 1) begin
      n_fail++;
      $display("FAIL main_done_timing got rise cycle %0d want %0d", done_rise_cyc, last_we_cyc + 1);
    end
    n_checks++;
    if (both_high != 0) begin
      n_fail++;
      $display("FAIL main_exclusive got %0d cycles with both strobes want 0", both_high);
    end
    send_all(-1);
    n_checks++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL main_ignore_after_done got %0d writes want 3", got_q.size());
    end
    $display("test_main: %0d writes, done=%b err=%b", got_q.size(), DONE, ERR);
  endtask

  task automatic test_zero_len();
    do_reset();
    bytes_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_all(-1);
    n_checks++;
    if (got_q.size() != 0 || DONE !== 1'b1 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len got writes=%0d done=%b err=%b want 0 1 0", got_q.size(), DONE, ERR);
    end
    $display("test_zero_len: writes=%0d done=%b", got_q.size(), DONE);
  endtask

  task automatic test_overflow();
    do_reset();
    bytes_q = '{8'h00, 8'h00, 8'h00, 8'hC9, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h11, 8'h22, 8'h33, 8'h44};
    send_all(-1);
    n_checks++;
    if (got_q.size() != 0 || DONE !== 1'b0 || ERR !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow got writes=%0d done=%b err=%b busy=%b want 0 0 1 0",
               got_q.size(), DONE, ERR, BUSY);
    end
    $display("test_overflow: err=%b done=%b", ERR, DONE);
  endtask

  task automatic test_framing();
    do_reset();
    load_main_image();
    send_all(5);
    run_model(5);
    n_checks++;
    if (got_q.size() != exp_q.size() || ERR !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL framing got writes=%0d err=%b done=%b busy=%b want %0d 1 0 0",
               got_q.size(), ERR, DONE, BUSY, exp_q.size());
    end
    $display("test_framing: writes=%0d err=%b", got_q.size(), ERR);
  endtask

  task automatic test_glitch();
    do_reset();
    RXD = 1'b0;
    tick(1);
    RXD = 1'b1;
    tick(12);
    n_checks++;
    if (BUSY !== 1'b0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_idle got busy=%b writes=%0d want 0 0", BUSY, got_q.size());
    end
    load_main_image();
    send_all(-1);
    run_model(-1);
    n_checks++;
    if (got_q.size() != exp_q.size() || DONE !== exp_done) begin
      n_fail++;
      $display("FAIL glitch_image got writes=%0d done=%b want %0d %b",
               got_q.size(), DONE, exp_q.size(), exp_done);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL glitch_wr%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("test_glitch: writes=%0d done=%b", got_q.size(), DONE);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bytes_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01};
    for (int i = 0; i < bytes_q.size(); i++) send_byte(bytes_q[i], 1'b1);
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(2);
    load_main_image();
    send_all(-1);
    run_model(-1);
    n_checks++;
    if (got_q.size() != exp_q.size() || DONE !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid got writes=%0d done=%b want %0d 1", got_q.size(), DONE, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid_wr%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("test_reset_mid: writes=%0d done=%b", got_q.size(), DONE);
  endtask

  task automatic test_random(input int iter);
    int n, m, bad;
    do_reset();
    bytes_q.delete();
    n = $urandom_range(0, 4);
    m = $urandom_range(0, 4);
    if ($urandom_range(0, 5) == 0) n = $urandom_range(IMEM_D + 1, IMEM_D + 60);
    for (int b = 3; b >= 0; b--) bytes_q.push_back(8'(n >> (8 * b)));
    for (int i = 0; i < n && i < 8; i++)
      for (int b = 0; b < 4; b++) bytes_q.push_back(8'($urandom));
    for (int b = 3; b >= 0; b--) bytes_q.push_back(8'(m >> (8 * b)));
    for (int i = 0; i < m; i++)
      for (int b = 0; b < 4; b++) bytes_q.push_back(8'($urandom));
    bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, bytes_q.size() - 1) : -1;
    send_all(bad);
    run_model(bad);
    n_checks++;
    if (got_q.size() != exp_q.size() || DONE !== exp_done || ERR !== exp_err) begin
      n_fail++;
      $display("FAIL rand%0d_status got writes=%0d done=%b err=%b want %0d %b %b",
               iter, got_q.size(), DONE, ERR, exp_q.size(), exp_done, exp_err);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand%0d_wr%0d got %h want %h", iter, i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (both_high != 0) begin
      n_fail++;
      $display("FAIL rand%0d_exclusive got %0d want 0", iter, both_high);
    end
    $display("test_random %0d: N=%0d M=%0d bad=%0d writes=%0d done=%b err=%b",
             iter, n, m, bad, got_q.size(), DONE, ERR);
  endtask

  initial begin
    RST = 1'b1;
    RXD = 1'b1;
    done_prev = 1'b0;
    test_reset();
    test_main();
    test_zero_len();
    test_overflow();
    test_framing();
    test_glitch();
    test_reset_mid();
    for (int it = 0; it < 6; it++) test_random(it);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Upstream loader for the single-cycle core. It receives the program image and the initial data image over a UART serial line, assembles 32-bit words, and drives write ports into instruction memory and data memory.
- It asserts DONE when the image is complete. DONE replaces the manual SW_W start switch as the core's INIT->RUN trigger.
- It replaces the fixed instruction-ROM modules and the simulation-only file read of data memory.

Parameters:
- CLKS_PER_BIT, 868: CLK cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- IMEM_DEPTH, 200: instruction memory depth in words.
- DMEM_DEPTH, 200: data memory depth in words.

Ports:
- CLK  input  1  system clock; all logic is on posedge.
- RST  input  1  synchronous, active-high reset.
- RXD  input  1  UART serial input, 8N1, LSB first, idle high. Asynchronous to CLK.
- IMEM_WE  output  1  one-cycle instruction-memory write strobe.
- DMEM_WE  output  1  one-cycle data-memory write strobe.
- WADDR  output  32  word address for the current write.
- WDATA  output  32  assembled word.
- BUSY  output  1  high from the first start bit until DONE or ERR.
- DONE  output  1  level; high once the complete image has been written.
- ERR  output  1  sticky; framing error or length overflow.

Behaviour:
- Reset values: IMEM_WE=0, DMEM_WE=0, WADDR=0, WDATA=0, BUSY=0, DONE=0, ERR=0. Loader state = INST_LEN, byte index 0, word counters 0.
- RST mid-operation aborts the load immediately. Nothing further is written. The next frame is parsed as a new INST_LEN header.
- RXD synchronisation: 2-FF synchroniser before any use.
- Receiver states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - IDLE->START on a synchronised falling edge.
  - In START, the line is re-checked at CLKS_PER_BIT/2. If high, it is a glitch: return to IDLE with no byte.
  - DATA samples 8 bits, each CLKS_PER_BIT after the previous sample (bit centres), LSB first.
  - STOP samples once more. Stop=1 raises an internal byte strobe in the next cycle. Stop=0 sets ERR and discards the byte.
  - Return to IDLE after the stop sample.
- Word assembly: big-endian; the first byte received is WDATA[31:24]. Byte index 0..3 wraps to 0 after the 4th byte.
- Loader FSM (advances on each completed word), ordered INST_LEN -> INST -> DATA_LEN -> DATA -> DONE:
  - INST_LEN: word = N, the instruction word count.
    - N > IMEM_DEPTH: set ERR, go to DONE_ERR.
    - N = 0: go to DATA_LEN.
    - Otherwise: go to INST.
  - INST: the k-th word (k = 0..N-1) writes IMEM_WE=1, WADDR=k, WDATA=word. After word N-1, go to DATA_LEN.
  - DATA_LEN: word = M. Same checks against DMEM_DEPTH. M = 0 goes to DONE.
  - DATA: the k-th word writes DMEM_WE=1, WADDR=k. After word M-1, go to DONE.
  - DONE: DONE=1, BUSY=0. All further RXD bytes are ignored until RST.
  - DONE_ERR: ERR=1, BUSY=0, DONE stays 0. Bytes are ignored until RST.
- Latency: the write strobe is high exactly one cycle, in the cycle after the 4th byte's strobe. WADDR/WDATA hold their values until the next write.
- DONE rises in the cycle after the final write strobe, or after the length word when the length is zero.
- IMEM_WE and DMEM_WE are never high together.
- Framing error mid-word: the byte is dropped, ERR is set, and the FSM moves to DONE_ERR with no further writes.
- Word counters are 32-bit. Comparisons use unsigned arithmetic.

Test Plan (CLKS_PER_BIT=4 on the bench):
- Send bytes 00 00 00 02 | 20 01 00 05 | 08 00 00 00 | 00 00 00 01 | 00 00 00 2A.
  -> IMEM writes (0, 0x20010005) and (1, 0x08000000), then DMEM write (0, 0x0000002A).
  -> DONE=1 one cycle after the DMEM strobe; ERR=0; exactly 3 write strobes total.
- N=0, M=0 (8 zero bytes) -> no write strobes; DONE=1 after the 8th byte.
- N=201 with IMEM_DEPTH=200 -> ERR=1, DONE=0, no writes; subsequent bytes are ignored.
- Stop bit forced to 0 on the 6th byte -> ERR=1; only the writes completed before it have occurred; BUSY=0.
- 1-cycle low glitch on RXD while idle -> no byte received; the state remains INST_LEN.
- RST asserted after 2 of 4 INST-word bytes, then a full valid image is sent -> the writes match the new image from address 0; no partial word is written.
